// File: rtl/lowf_q_pkg.sv
// Shared types, default sizing and address helpers for the low-frequency
// sample queue sequencer.
package lowf_q_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_WINDOW = 1021;
   localparam int DEF_DECIM  = 2;
   localparam int DEF_RD_LAT = 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      BURST = ST_BURST
   } state_t;

   // Callers truncate the result to their address width, which yields the
   // natural modulo-DEPTH wrap.
   function automatic logic [31:0] wrap_sub(input logic [31:0] a, input logic [31:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/lowf_q_wr_ctrl.sv
// Write side of the sample queue: decimates wrt_smpl strobes, owns the write
// pointer and the saturating fill count, and raises a burst request.
module lowf_q_wr_ctrl
   import lowf_q_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WINDOW = DEF_WINDOW,
   parameter int DECIM  = DEF_DECIM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wrt_smpl,
   output logic              accept,
   output logic              req,
   output logic              full,
   output logic [ADDR_W-1:0] wptr,
   output logic [ADDR_W-1:0] wptr_new
);

   localparam int                DEC_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DEC_W-1:0]  DEC_MAX = DEC_W'(DECIM - 1);
   localparam logic [ADDR_W-1:0] WIN     = ADDR_W'(WINDOW);

   logic [DEC_W-1:0]  dec_cnt;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_new;

   // clr blocks the write in its own cycle so a flush never leaves a stray sample.
   assign accept   = wrt_smpl & ~clr & (dec_cnt == '0);
   assign cnt_new  = (cnt == WIN) ? cnt : cnt + 1'b1;
   assign wptr_new = accept ? wptr + 1'b1 : wptr;
   assign req      = accept & (cnt_new == WIN);
   assign full     = (cnt == WIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_cnt <= '0;
         wptr    <= '0;
         cnt     <= '0;
      end else if (clr) begin
         dec_cnt <= '0;
         wptr    <= '0;
         cnt     <= '0;
      end else begin
         if (wrt_smpl) begin
            dec_cnt <= (dec_cnt == DEC_MAX) ? '0 : dec_cnt + 1'b1;
         end
         if (accept) begin
            wptr <= wptr_new;
            cnt  <= cnt_new;
         end
      end
   end

endmodule

// File: rtl/lowf_queue_sequencer.sv
// Low-frequency circular queue controller: writes decimated samples into the
// dual-port RAM and replays the full window oldest-to-newest on every accept.
module lowf_queue_sequencer
   import lowf_q_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WINDOW = DEF_WINDOW,
   parameter int DECIM  = DEF_DECIM,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wrt_smpl,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W-1:0] raddr,
   output logic              smpl_vld,
   output logic              smpl_last,
   output logic              sequencing,
   output logic              full,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] WIN = ADDR_W'(WINDOW);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic              accept;
   logic              req;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] wptr_new;
   logic [ADDR_W-1:0] base;

   state_t            state;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_left;
   logic [ADDR_W-1:0] raddr_q;
   logic              pending;
   logic              overrun_q;
   logic              issue;
   logic              last_issue;
   logic [RD_LAT-1:0] vld_sr;
   logic [RD_LAT-1:0] last_sr;

   lowf_q_wr_ctrl #(
      .ADDR_W (ADDR_W),
      .WINDOW (WINDOW),
      .DECIM  (DECIM)
   ) u_wr_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .wrt_smpl (wrt_smpl),
      .accept   (accept),
      .req      (req),
      .full     (full),
      .wptr     (wptr),
      .wptr_new (wptr_new)
   );

   assign we    = accept;
   assign waddr = wptr;

   // Oldest sample of the window that ends with whatever is written this cycle.
   assign base = ADDR_W'(wrap_sub(32'(wptr_new), 32'(WINDOW)));

   assign issue      = (state == BURST);
   assign last_issue = issue & (rd_left == ONE);
   assign raddr      = issue ? rd_ptr : raddr_q;
   assign sequencing = issue;
   assign smpl_vld   = vld_sr[RD_LAT-1];
   assign smpl_last  = last_sr[RD_LAT-1];
   assign overrun    = overrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         rd_left   <= '0;
         raddr_q   <= '0;
         pending   <= 1'b0;
         overrun_q <= 1'b0;
         vld_sr    <= '0;
         last_sr   <= '0;
      end else if (clr) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         rd_left   <= '0;
         raddr_q   <= '0;
         pending   <= 1'b0;
         overrun_q <= 1'b0;
         vld_sr    <= '0;
         last_sr   <= '0;
      end else begin
         vld_sr[0]  <= issue;
         last_sr[0] <= last_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            last_sr[i] <= last_sr[i-1];
         end

         case (state)
            IDLE: begin
               if (req) begin
                  state   <= BURST;
                  rd_ptr  <= base;
                  rd_left <= WIN;
               end
            end
            BURST: begin
               raddr_q <= rd_ptr;
               if (last_issue) begin
                  // A waiting or coincident request chains straight into the next burst.
                  if (pending | req) begin
                     rd_ptr  <= base;
                     rd_left <= WIN;
                     pending <= 1'b0;
                     if (pending & req) begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  rd_left <= rd_left - 1'b1;
                  if (req) begin
                     pending <= 1'b1;
                     if (pending) begin
                        overrun_q <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lowf_queue_sequencer.sv
// Randomized bench for lowf_queue_sequencer with a sample-history reference
// model, a RAM stand-in and an expected-window scoreboard.
module tb_lowf_queue_sequencer;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int WINDOW = 13;
   localparam int DECIM  = 2;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic              wrt_smpl = 1'b0;
   logic [15:0]       din = '0;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr;
   logic              smpl_vld;
   logic              smpl_last;
   logic              sequencing;
   logic              full;
   logic              overrun;

   logic [15:0]       mem [DEPTH];
   logic [15:0]       rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [16:0] exp_q[$];
   logic [15:0] hist[$];
   int          m_strobes = 0;
   int          m_wptr = 0;
   int          reads_left = 0;
   int          bursts = 0;
   int          lasts_seen = 0;
   bit          pending = 1'b0;
   bit          m_overrun = 1'b0;

   always #5 clk = ~clk;

   lowf_queue_sequencer #(
      .ADDR_W (ADDR_W),
      .WINDOW (WINDOW),
      .DECIM  (DECIM),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .wrt_smpl   (wrt_smpl),
      .we         (we),
      .waddr      (waddr),
      .raddr      (raddr),
      .smpl_vld   (smpl_vld),
      .smpl_last  (smpl_last),
      .sequencing (sequencing),
      .full       (full),
      .overrun    (overrun)
   );

   // RAM stand-in with one cycle read latency
   always @(posedge clk) begin
      if (we) mem[waddr] <= din;
      rdata <= mem[raddr];
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void start_burst();
      for (int i = 0; i < WINDOW; i++) exp_q.push_back({i == WINDOW - 1, hist[i]});
      reads_left = WINDOW;
      bursts++;
   endfunction

   // Reference model: history of accepted samples and burst scheduling
   always @(posedge clk) begin : model
      bit acc;
      bit req;
      if (!rst_n || clr) begin
         foreach (exp_q[i]) if (exp_q[i][16]) bursts--;
         exp_q.delete();
         hist.delete();
         m_strobes  = 0;
         m_wptr     = 0;
         reads_left = 0;
         pending    = 1'b0;
         m_overrun  = 1'b0;
      end else begin
         acc = wrt_smpl && (m_strobes % DECIM == 0);
         if (wrt_smpl) m_strobes++;
         if (acc) begin
            hist.push_back(din);
            if (hist.size() > WINDOW) void'(hist.pop_front());
            m_wptr = (m_wptr + 1) % DEPTH;
         end
         req = acc && (hist.size() == WINDOW);
         if (reads_left > 0) begin
            reads_left--;
            if (reads_left == 0) begin
               if (pending || req) begin
                  if (pending && req) m_overrun = 1'b1;
                  pending = 1'b0;
                  start_burst();
               end
            end else if (req) begin
               if (pending) m_overrun = 1'b1;
               pending = 1'b1;
            end
         end else if (req) begin
            start_burst();
         end
      end
   end

   // Monitor: compares every cycle away from the active edge
   always @(negedge clk) begin
      logic [16:0] e;
      if (rst_n) begin
         check("we", we, wrt_smpl && !clr && (m_strobes % DECIM == 0));
         if (we) check("waddr", waddr, m_wptr);
         check("full", full, hist.size() == WINDOW);
         check("sequencing", sequencing, reads_left > 0);
         check("overrun", overrun, m_overrun);
         if (smpl_vld) begin
            if (smpl_last) lasts_seen++;
            if (exp_q.size() == 0) begin
               check("smpl_vld_unexpected", smpl_vld, 0);
            end else begin
               e = exp_q.pop_front();
               check("smpl_data", rdata, e[15:0]);
               check("smpl_last", smpl_last, e[16]);
            end
         end
      end
   end

   task automatic cyc(input logic s);
      wrt_smpl = s;
      din = 16'($urandom);
      @(posedge clk);
      #1;
      wrt_smpl = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   task automatic fill();
      for (int i = 0; i < 2 * WINDOW; i++) begin
         cyc(1'b1);
         cyc(1'b0);
      end
   endtask

   initial begin
      int l0;
      @(posedge clk);
      #1;
      check("reset_state", {we, waddr, raddr, smpl_vld, smpl_last, sequencing, full, overrun}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // first fill: 13 accepts then one burst
      l0 = lasts_seen;
      fill();
      idle(20);
      check("fill_bursts", lasts_seen - l0, 1);

      // ten spaced accepts, each its own burst, pointer wraps
      l0 = lasts_seen;
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1);
         idle(19);
         cyc(1'b1);
         idle(19);
      end
      check("wrap_bursts", lasts_seen - l0, 10);

      // three accepts inside one burst coalesce into one extra burst
      l0 = lasts_seen;
      for (int k = 0; k < 6; k++) cyc(1'b1);
      idle(40);
      check("overrun_bursts", lasts_seen - l0, 2);
      check("overrun_sticky", overrun, 1);

      // accept landing on the last read of a burst
      l0 = lasts_seen;
      for (int k = 0; k < 14; k++) cyc(k == 0 || k == 5 || k == 13);
      idle(40);
      check("coincident_bursts", lasts_seen - l0, 2);

      for (int k = 0; k < 300; k++) cyc($urandom_range(0, 3) == 0);
      idle(40);

      // clr in the middle of a burst
      clr = 1'b1;
      cyc(1'b0);
      clr = 1'b0;
      l0 = lasts_seen;
      fill();
      idle(1);
      clr = 1'b1;
      cyc(1'b0);
      clr = 1'b0;
      idle(3);
      check("abort_no_vld", {smpl_vld, full, overrun, sequencing}, 0);
      fill();
      idle(20);
      check("abort_refill_bursts", lasts_seen - l0, 1);

      // async reset in the middle of a burst
      cyc(1'b1);
      idle(3);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", {we, waddr, raddr, smpl_vld, smpl_last, sequencing, full, overrun}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      wrt_smpl = 1'b1;
      din = 16'($urandom);
      @(negedge clk);
      check("post_reset_waddr", {we, waddr}, {1'b1, 4'd0});
      @(posedge clk);
      #1;
      wrt_smpl = 1'b0;
      idle(5);

      check("drain_empty", exp_q.size(), 0);
      check("burst_total", lasts_seen, bursts);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
